// File: rtl/eviction_drain_pkg.sv
// ============================================================================
// Module   : eviction_drain_pkg
// Brief    : Shared FSM states, status codes and word layout for the drain.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package eviction_drain_pkg;

   typedef logic [2:0] drain_state_t;

   localparam drain_state_t S_IDLE  = 3'd0;
   localparam drain_state_t S_ADDR  = 3'd1;
   localparam drain_state_t S_WAIT  = 3'd2;
   localparam drain_state_t S_PUSH  = 3'd3;
   localparam drain_state_t S_CLEAR = 3'd4;

   localparam logic [1:0] STATUS_RANDOM = 2'b10;
   localparam logic [1:0] STATUS_EXPIRY = 2'b01;
   localparam logic [1:0] STATUS_MULTI  = 2'b00;

   localparam int STATUS_MSB = 31;
   localparam int STATUS_LSB = 30;
   localparam int TRACE_W    = 30;

endpackage

`default_nettype wire

// File: rtl/drain_latency_timer.sv
// ============================================================================
// Module   : drain_latency_timer
// Brief    : Load/decrement counter with zero flag covering tracker read latency.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module drain_latency_timer #(
   parameter int RD_LATENCY = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_load,
   input  logic i_dec,
   output logic o_zero
);

   localparam int TW = $clog2(RD_LATENCY + 1);

   logic [TW-1:0] r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= TW'(RD_LATENCY - 1);
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - TW'(1);
      end
   end

   assign o_zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/eviction_tracker_drain.sv
// ============================================================================
// Module   : eviction_tracker_drain
// Brief    : Walks the eviction tracker buffer and streams packed words to host.
//            Define EVICTION_DRAIN_AUTO_EN to trigger on tracker_stall_i rising.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module eviction_tracker_drain
   import eviction_drain_pkg::*;
#(
   parameter int COUNTER_BW   = 30,
   parameter int BUFFER_LIMIT = 4096,
   parameter int BW_BUFFER    = $clog2(BUFFER_LIMIT),
   parameter int RD_LATENCY   = 2
) (
   input  logic                  clock_i,
   input  logic                  resetn_i,
   input  logic                  start_i,
   input  logic                  tracker_stall_i,
   input  logic [31:0]           tracker_count_i,
   input  logic [COUNTER_BW-1:0] tracker_trace_i,
   input  logic [1:0]            tracker_status_i,
   output logic [BW_BUFFER-1:0]  rd_addr_o,
   output logic                  clear_o,
   output logic [31:0]           data_o,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [31:0]           words_o
);

   // One extra index bit lets N == BUFFER_LIMIT terminate without wrapping.
   localparam int IDX_W = BW_BUFFER + 1;

   drain_state_t         r_state;
   logic [IDX_W-1:0]     r_index;
   logic [IDX_W-1:0]     r_n;
   logic [BW_BUFFER-1:0] r_rd_addr;
   logic [31:0]          r_data;
   logic [31:0]          r_words;
   logic                 r_valid;

   logic                 w_trigger;
   logic                 w_timer_zero;
   logic [IDX_W-1:0]     w_n_cap;
   logic [IDX_W-1:0]     w_index_nxt;

`ifdef EVICTION_DRAIN_AUTO_EN
   logic r_stall_q;

   always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) r_stall_q <= 1'b0;
      else           r_stall_q <= tracker_stall_i;
   end

   assign w_trigger = start_i | (tracker_stall_i & ~r_stall_q);
`else
   logic w_unused_stall;
   assign w_unused_stall = tracker_stall_i;
   assign w_trigger      = start_i;
`endif

   assign w_n_cap     = (tracker_count_i > 32'(BUFFER_LIMIT)) ? IDX_W'(BUFFER_LIMIT)
                                                              : IDX_W'(tracker_count_i);
   assign w_index_nxt = r_index + IDX_W'(1);

   drain_latency_timer #(
      .RD_LATENCY (RD_LATENCY)
   ) u_timer (
      .i_clk   (clock_i),
      .i_rst_n (resetn_i),
      .i_load  (r_state == S_ADDR),
      .i_dec   (r_state == S_WAIT),
      .o_zero  (w_timer_zero)
   );

   always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
         r_state   <= S_IDLE;
         r_index   <= '0;
         r_n       <= '0;
         r_rd_addr <= '0;
         r_data    <= '0;
         r_words   <= '0;
         r_valid   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_trigger) begin
                  r_n     <= w_n_cap;
                  r_index <= '0;
                  r_words <= '0;
                  r_state <= (w_n_cap == '0) ? S_CLEAR : S_ADDR;
               end
            end
            S_ADDR: begin
               r_rd_addr <= r_index[BW_BUFFER-1:0];
               r_state   <= S_WAIT;
            end
            S_WAIT: begin
               if (w_timer_zero) begin
                  r_data[STATUS_MSB:STATUS_LSB] <= tracker_status_i;
                  r_data[TRACE_W-1:0]           <= TRACE_W'(tracker_trace_i);
                  r_valid                       <= 1'b1;
                  r_state                       <= S_PUSH;
               end
            end
            S_PUSH: begin
               if (ready_i) begin
                  r_valid <= 1'b0;
                  r_words <= r_words + 32'd1;
                  r_index <= w_index_nxt;
                  r_state <= (w_index_nxt == r_n) ? S_CLEAR : S_ADDR;
               end
            end
            S_CLEAR: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign rd_addr_o = r_rd_addr;
   assign data_o    = r_data;
   assign valid_o   = r_valid;
   assign words_o   = r_words;
   assign clear_o   = (r_state == S_CLEAR);
   assign done_o    = (r_state == S_CLEAR);
   assign busy_o    = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_eviction_tracker_drain.sv
// ============================================================================
// Module   : tb_eviction_tracker_drain
// Brief    : Randomized self-checking bench for eviction_tracker_drain.
//            Honours EVICTION_DRAIN_AUTO_EN for the stall-trigger scenario.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_eviction_tracker_drain;

   localparam int CBW = 20;
   localparam int BL  = 4096;
   localparam int BW  = 12;
   localparam int RDL = 2;

   logic            clk = 1'b0;
   logic            resetn_i = 1'b0;
   logic            start_i = 1'b0;
   logic            tracker_stall_i = 1'b0;
   logic [31:0]     tracker_count_i = '0;
   logic [CBW-1:0]  tracker_trace_i;
   logic [1:0]      tracker_status_i;
   logic [BW-1:0]   rd_addr_o;
   logic            clear_o;
   logic [31:0]     data_o;
   logic            valid_o;
   logic            ready_i = 1'b0;
   logic            busy_o;
   logic            done_o;
   logic [31:0]     words_o;

   logic [1:0]      st_mem [BL];
   logic [CBW-1:0]  tr_mem [BL];
   logic [BW-1:0]   addr_d;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Tracker model: data appears RDL-1 edges after the address changes.
   always @(posedge clk) addr_d <= rd_addr_o;
   assign tracker_status_i = st_mem[addr_d];
   assign tracker_trace_i  = tr_mem[addr_d];

   eviction_tracker_drain #(
      .COUNTER_BW   (CBW),
      .BUFFER_LIMIT (BL),
      .RD_LATENCY   (RDL)
   ) dut (
      .clock_i          (clk),
      .resetn_i         (resetn_i),
      .start_i          (start_i),
      .tracker_stall_i  (tracker_stall_i),
      .tracker_count_i  (tracker_count_i),
      .tracker_trace_i  (tracker_trace_i),
      .tracker_status_i (tracker_status_i),
      .rd_addr_o        (rd_addr_o),
      .clear_o          (clear_o),
      .data_o           (data_o),
      .valid_o          (valid_o),
      .ready_i          (ready_i),
      .busy_o           (busy_o),
      .done_o           (done_o),
      .words_o          (words_o)
   );

   task automatic fill_mem();
      for (int i = 0; i < BL; i++) begin
         st_mem[i] = 2'($urandom_range(0, 3));
         tr_mem[i] = CBW'($urandom);
      end
   endtask

   // Drives one drain and checks every word, its timing and the clear pulse
   // against the expected buffer contents.
   task automatic run_drain(input int cnt, input int rdy_pct, input int hold_word,
                            input int hold_len, input bit noise, input bit via_stall,
                            input string tag);
      int n, k, cyc, last_hs, hold_cnt, exp_at, budget;
      logic [31:0] exp_w, prev_data;
      bit prev_valid, finished;
      n = (cnt > BL) ? BL : cnt;
      budget = 200 + (n + 1) * (RDL + 2) * 12;
      @(negedge clk);
      tracker_count_i = 32'(cnt);
      if (via_stall) tracker_stall_i = 1'b1; else start_i = 1'b1;
      k = 0; cyc = 0; last_hs = 0; hold_cnt = 0; exp_at = 2 + RDL;
      prev_valid = 0; finished = 0; prev_data = '0;
      while (!finished && cyc < budget) begin
         @(negedge clk);
         cyc++;
         start_i = 1'b0;
         if (noise) begin
            start_i = ($urandom_range(0, 3) == 0);
            tracker_count_i = $urandom_range(0, BL + 20);
         end
         checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL %s busy: got %b exp 1 cyc %0d", tag, busy_o, cyc); end
         if (clear_o === 1'b1) begin
            checks++; if (k != n) begin errors++; $display("FAIL %s word_count: got %0d exp %0d", tag, k, n); end
            checks++; if (cyc != ((n == 0) ? 1 : last_hs + 1)) begin errors++; $display("FAIL %s clear_time: got %0d exp %0d", tag, cyc, (n == 0) ? 1 : last_hs + 1); end
            checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL %s done: got %b exp 1", tag, done_o); end
            checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL %s valid_in_clear: got %b exp 0", tag, valid_o); end
            finished = 1;
            start_i = 1'b1;
         end else begin
            checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL %s early_done: got %b exp 0 cyc %0d", tag, done_o, cyc); end
            if (valid_o === 1'b1) begin
               exp_w = (32'(st_mem[k]) << 30) | 32'(tr_mem[k]);
               checks++; if (k >= n) begin errors++; $display("FAIL %s extra_word: got index %0d exp below %0d", tag, k, n); end
               checks++; if (data_o !== exp_w) begin errors++; $display("FAIL %s data[%0d]: got %h exp %h", tag, k, data_o, exp_w); end
               checks++; if (rd_addr_o !== BW'(k)) begin errors++; $display("FAIL %s rd_addr[%0d]: got %0d exp %0d", tag, k, rd_addr_o, k); end
               if (!prev_valid) begin
                  checks++; if (cyc != exp_at) begin errors++; $display("FAIL %s latency[%0d]: got %0d exp %0d", tag, k, cyc, exp_at); end
                  checks++; if (words_o !== 32'(k)) begin errors++; $display("FAIL %s words_mid: got %0d exp %0d", tag, words_o, k); end
               end else begin
                  checks++; if (data_o !== prev_data) begin errors++; $display("FAIL %s hold_stable: got %h exp %h", tag, data_o, prev_data); end
               end
               prev_data = data_o;
               if (k == hold_word && hold_cnt < hold_len) begin
                  ready_i = 1'b0;
                  hold_cnt++;
               end else begin
                  ready_i = ($urandom_range(1, 100) <= rdy_pct);
               end
               if (ready_i) begin
                  last_hs = cyc; k++; exp_at = cyc + RDL + 2; prev_valid = 0;
               end else begin
                  prev_valid = 1;
               end
            end else begin
               checks++; if (prev_valid) begin errors++; $display("FAIL %s valid_dropped: got 0 exp 1 cyc %0d", tag, cyc); end
               prev_valid = 0;
               ready_i = 1'($urandom_range(0, 1));
            end
         end
      end
      if (!finished) begin
         errors++;
         $display("FAIL %s timeout: got no clear_o exp clear within %0d cycles", tag, budget);
      end
      @(negedge clk);
      start_i = 1'b0; ready_i = 1'b0; tracker_stall_i = 1'b0;
      checks++; if (clear_o !== 1'b0) begin errors++; $display("FAIL %s clear_width: got %b exp 0", tag, clear_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL %s busy_after: got %b exp 0", tag, busy_o); end
      checks++; if (words_o !== 32'(n)) begin errors++; $display("FAIL %s words_final: got %0d exp %0d", tag, words_o, n); end
   endtask

   task automatic test_reset();
      resetn_i = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (rd_addr_o !== '0) begin errors++; $display("FAIL reset rd_addr: got %h exp 0", rd_addr_o); end
      checks++; if ({clear_o, valid_o, busy_o, done_o} !== 4'b0) begin errors++; $display("FAIL reset flags: got %b exp 0000", {clear_o, valid_o, busy_o, done_o}); end
      checks++; if (data_o !== '0) begin errors++; $display("FAIL reset data: got %h exp 0", data_o); end
      checks++; if (words_o !== '0) begin errors++; $display("FAIL reset words: got %0d exp 0", words_o); end
      resetn_i = 1'b1;
   endtask

   task automatic test_basic();
      fill_mem();
      st_mem[0] = 2'b10; tr_mem[0] = CBW'(5);
      st_mem[1] = 2'b01; tr_mem[1] = CBW'(6);
      st_mem[2] = 2'b00; tr_mem[2] = CBW'(7);
      run_drain(3, 100, -1, 0, 0, 0, "basic");
   endtask

   task automatic test_empty();
      fill_mem();
      run_drain(0, 100, -1, 0, 0, 0, "empty");
   endtask

   task automatic test_backpressure();
      fill_mem();
      run_drain(4, 100, 1, 5, 0, 0, "hold5");
   endtask

   task automatic test_random();
      for (int t = 0; t < 6; t++) begin
         fill_mem();
         run_drain($urandom_range(1, 40), 60, -1, 0, 1, 0, "random");
      end
   endtask

   task automatic test_limit();
      fill_mem();
      run_drain(BL + 10, 100, -1, 0, 0, 0, "limit");
      checks++; if (rd_addr_o !== BW'(BL - 1)) begin errors++; $display("FAIL limit last_addr: got %0d exp %0d", rd_addr_o, BL - 1); end
   endtask

   task automatic test_auto_trigger();
`ifdef EVICTION_DRAIN_AUTO_EN
      fill_mem();
      run_drain(5, 100, -1, 0, 0, 1, "auto");
`else
      @(negedge clk);
      tracker_count_i = 32'd5;
      tracker_stall_i = 1'b1;
      repeat (8) begin
         @(negedge clk);
         checks++; if (busy_o !== 1'b0 || valid_o !== 1'b0) begin errors++; $display("FAIL no_auto: got busy %b valid %b exp 0 0", busy_o, valid_o); end
      end
      tracker_stall_i = 1'b0;
`endif
   endtask

   task automatic test_reset_mid_drain();
      int seen, cyc;
      fill_mem();
      @(negedge clk);
      tracker_count_i = 32'd4; start_i = 1'b1; ready_i = 1'b1;
      seen = 0; cyc = 0;
      while (seen < 2 && cyc < 100) begin
         @(negedge clk);
         start_i = 1'b0; cyc++;
         if (valid_o === 1'b1) seen++;
      end
      checks++; if (seen != 2) begin errors++; $display("FAIL midreset reach_word2: got %0d exp 2", seen); end
      ready_i = 1'b0;
      #2 resetn_i = 1'b0;
      #1;
      checks++; if ({valid_o, busy_o, clear_o, done_o} !== 4'b0) begin errors++; $display("FAIL midreset flags: got %b exp 0000", {valid_o, busy_o, clear_o, done_o}); end
      checks++; if (data_o !== '0 || words_o !== '0 || rd_addr_o !== '0) begin errors++; $display("FAIL midreset regs: got %h %0d %0d exp 0 0 0", data_o, words_o, rd_addr_o); end
      repeat (3) begin
         @(negedge clk);
         checks++; if (clear_o !== 1'b0) begin errors++; $display("FAIL midreset clear: got %b exp 0", clear_o); end
      end
      resetn_i = 1'b1;
      run_drain(4, 100, -1, 0, 0, 0, "redrain");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_empty();
      test_backpressure();
      test_random();
      test_auto_trigger();
      test_reset_mid_drain();
      test_limit();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
